segment_display_scanner: RTL and testbench

Time-multiplexed driver for a 4-digit common-anode 7-segment display. It sits directly downstream of the stopwatch's four hex decoders and takes their per-digit segment patterns. It drives one shared segment bus plus four digit anodes, scanning the digits in turn. A programmable blanking interval between digit slots suppresses ghosting. Segment patterns are latched per slot so the display never tears mid-slot.

---
 rtl/segment_display_scanner.sv | 164 ++++++++++++++++
 tb/tb_segment_display_scanner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/segment_display_scanner.sv
// ---------------------------------------------------------------------------
// segment_display_scanner
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Each digit owns a slot of REFRESH_DIV cycles. The first BLANK_CYCLES of
//   a slot keep everything dark (anti-ghosting). At the end of the blank
//   interval the digit's segment pattern, decimal point and enable are
//   latched into shadow registers, so the lit digit never changes mid-slot.
//
// Ports
//   Clk        : system clock
//   Reset      : asynchronous, active-high reset
//   Enable     : 1 = scan, 0 = dark with scan held at slot 0 / BLANK
//   DigitMask  : per-digit enable (bit i lights digit i's slot)
//   DotMask    : per-digit decimal point request
//   Seg0..Seg3 : active-high segment patterns, one per digit
//   SegOut     : shared segment bus, polarity from SEG_ACTIVE_LOW
//   DpOut      : decimal point, polarity from SEG_ACTIVE_LOW
//   AnodeOut   : digit selects, one-hot or all-off, polarity from ANODE_ACTIVE_LOW
//   FrameTick  : one-cycle pulse after the last slot of each 4-slot frame
// ---------------------------------------------------------------------------
module segment_display_scanner #(
  parameter int unsigned REFRESH_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES     = 500,
  parameter bit          SEG_ACTIVE_LOW   = 1'b1,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Enable,
  input  logic [3:0] DigitMask,
  input  logic [3:0] DotMask,
  input  logic [6:0] Seg0,
  input  logic [6:0] Seg1,
  input  logic [6:0] Seg2,
  input  logic [6:0] Seg3,
  output logic [6:0] SegOut,
  output logic       DpOut,
  output logic [3:0] AnodeOut,
  output logic       FrameTick
);

  localparam int unsigned     CNT_W   = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  // Inactive levels; XOR with these converts active-high values to pin levels.
  localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [3:0] AN_OFF  = ANODE_ACTIVE_LOW ? 4'hF : 4'h0;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } phase_e;

  phase_e           phase_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       idx_q;
  logic [1:0]       idx_d;
  logic [6:0]       sh_seg_q;
  logic             sh_dp_q;
  logic             sh_en_q;
  logic [6:0]       seg_out_q;
  logic             dp_out_q;
  logic [3:0]       anode_q;
  logic             frame_tick_q;

  logic             wrap_c;
  logic             blank_c;
  logic             enter_show_c;
  logic [6:0]       seg_sel_c;
  logic [3:0]       oh_next_c;
  logic [3:0]       oh_cur_c;

  // Slot counter / digit index advance
  always_comb begin
    wrap_c = (cnt_q == CNT_MAX);
    cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
    idx_d  = wrap_c ? idx_q + 2'd1 : idx_q;
  end

  // Whether the next cycle still falls inside the blank interval
  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign blank_c = 1'b0;
  end else begin : g_blank
    assign blank_c = (cnt_d < CNT_W'(BLANK_CYCLES));
  end

  // Capture happens once per slot: leaving BLANK, or directly on the wrap
  // edge when there is no blank interval at all.
  assign enter_show_c = !blank_c && ((phase_q == BLANK) || wrap_c);

  // Pattern of the digit whose slot is about to be shown
  always_comb begin
    seg_sel_c = Seg0;
    case (idx_d)
      2'd0:    seg_sel_c = Seg0;
      2'd1:    seg_sel_c = Seg1;
      2'd2:    seg_sel_c = Seg2;
      default: seg_sel_c = Seg3;
    endcase
  end

  assign oh_next_c = 4'(4'b0001 << idx_d);
  assign oh_cur_c  = 4'(4'b0001 << idx_q);

  // Phase FSM, counters, shadows and registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      phase_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      sh_seg_q     <= 7'h00;
      sh_dp_q      <= 1'b0;
      sh_en_q      <= 1'b0;
      seg_out_q    <= SEG_OFF;
      dp_out_q     <= DP_OFF;
      anode_q      <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else if (!Enable) begin
      phase_q      <= BLANK;
      cnt_q        <= '0;
      idx_q        <= 2'd0;
      sh_seg_q     <= 7'h00;
      sh_dp_q      <= 1'b0;
      sh_en_q      <= 1'b0;
      seg_out_q    <= SEG_OFF;
      dp_out_q     <= DP_OFF;
      anode_q      <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      frame_tick_q <= wrap_c && (idx_q == 2'd3);
      if (enter_show_c) begin
        // Latch the new digit; DigitMask is frozen alongside the pattern.
        phase_q   <= SHOW;
        sh_seg_q  <= seg_sel_c;
        sh_dp_q   <= DotMask[idx_d];
        sh_en_q   <= DigitMask[idx_d];
        seg_out_q <= DigitMask[idx_d] ? (seg_sel_c ^ SEG_OFF) : SEG_OFF;
        dp_out_q  <= DigitMask[idx_d] ? (DotMask[idx_d] ^ DP_OFF) : DP_OFF;
        anode_q   <= DigitMask[idx_d] ? (oh_next_c ^ AN_OFF) : AN_OFF;
      end else if (wrap_c || (phase_q == BLANK)) begin
        phase_q   <= BLANK;
        seg_out_q <= SEG_OFF;
        dp_out_q  <= DP_OFF;
        anode_q   <= AN_OFF;
      end else begin
        // Mid-SHOW: outputs follow the shadows only, never the live inputs.
        phase_q   <= SHOW;
        seg_out_q <= sh_en_q ? (sh_seg_q ^ SEG_OFF) : SEG_OFF;
        dp_out_q  <= sh_en_q ? (sh_dp_q ^ DP_OFF) : DP_OFF;
        anode_q   <= sh_en_q ? (oh_cur_c ^ AN_OFF) : AN_OFF;
      end
    end
  end

  assign SegOut    = seg_out_q;
  assign DpOut     = dp_out_q;
  assign AnodeOut  = anode_q;
  assign FrameTick = frame_tick_q;

endmodule

// File: tb/tb_segment_display_scanner.sv
// ---------------------------------------------------------------------------
// tb_segment_display_scanner
//   Directed bench: REFRESH_DIV=8, BLANK_CYCLES=2 (main DUT) and a second
//   instance with BLANK_CYCLES=0, both active-low. Variable k is the cycle
//   number since the last reset release / re-enable (cnt = k%8, idx = k/8%4).
// ---------------------------------------------------------------------------
module tb_segment_display_scanner;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Enable;
  logic [3:0] DigitMask;
  logic [3:0] DotMask;
  logic [6:0] Seg0, Seg1, Seg2, Seg3;

  logic [6:0] SegOut;
  logic       DpOut;
  logic [3:0] AnodeOut;
  logic       FrameTick;

  logic [6:0] SegOutZ;
  logic       DpOutZ;
  logic [3:0] AnodeOutZ;
  logic       FrameTickZ;

  int checks = 0;
  int errors = 0;
  int k = 0;
  int ftc = 0;

  logic [6:0] m_seg [4];
  logic [3:0] m_dmask;
  logic [3:0] m_dot;

  always #5 Clk = ~Clk;

  segment_display_scanner #(
    .REFRESH_DIV(8), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .DigitMask(DigitMask), .DotMask(DotMask),
    .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3),
    .SegOut(SegOut), .DpOut(DpOut), .AnodeOut(AnodeOut), .FrameTick(FrameTick)
  );

  segment_display_scanner #(
    .REFRESH_DIV(8), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b1), .ANODE_ACTIVE_LOW(1'b1)
  ) dut0 (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .DigitMask(DigitMask), .DotMask(DotMask),
    .Seg0(Seg0), .Seg1(Seg1), .Seg2(Seg2), .Seg3(Seg3),
    .SegOut(SegOutZ), .DpOut(DpOutZ), .AnodeOut(AnodeOutZ), .FrameTick(FrameTickZ)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  task automatic drive_inputs();
    Seg0 = m_seg[0]; Seg1 = m_seg[1]; Seg2 = m_seg[2]; Seg3 = m_seg[3];
    DigitMask = m_dmask;
    DotMask   = m_dot;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
    k++;
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_anode"}, 32'(AnodeOut), 32'h0000_000F);
    chk({tag, "_seg"},   32'(SegOut),   32'h0000_007F);
    chk({tag, "_dp"},    32'(DpOut),    32'h1);
    chk({tag, "_ft"},    32'(FrameTick), 32'h0);
  endtask

  // Expected outputs of both instances from the cycle number and the
  // (slot-stable) input settings.
  task automatic check_model(input bit with_zero);
    int         cnt;
    int         idx;
    bit         show;
    bit         ft;
    bit         ok;
    logic [3:0] oh;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [3:0] inv;
    cnt  = k % 8;
    idx  = (k / 8) % 4;
    oh   = 4'(4'b0001 << idx);
    show = (cnt >= 2) && m_dmask[idx];
    ft   = (k > 0) && (k % 32 == 0);
    ea   = show ? ~oh : 4'hF;
    es   = show ? ~m_seg[idx] : 7'h7F;
    ed   = show ? ~m_dot[idx] : 1'b1;
    chk("anode", 32'(AnodeOut), 32'(ea));
    chk("seg",   32'(SegOut),   32'(es));
    chk("dp",    32'(DpOut),    32'(ed));
    chk("frametick", 32'(FrameTick), 32'(ft));
    inv = ~AnodeOut;
    ok  = ($countones(inv) <= 1);
    chk("onehot", 32'(ok), 32'h1);
    if (FrameTick === 1'b1) ftc++;
    if (with_zero) begin
      show = (k >= 1) && m_dmask[idx];
      ea   = show ? ~oh : 4'hF;
      es   = show ? ~m_seg[idx] : 7'h7F;
      chk("z_anode", 32'(AnodeOutZ), 32'(ea));
      chk("z_seg",   32'(SegOutZ),   32'(es));
      chk("z_ft",    32'(FrameTickZ), 32'(ft));
      inv = ~AnodeOutZ;
      ok  = ($countones(inv) <= 1);
      chk("z_onehot", 32'(ok), 32'h1);
    end
  endtask

  initial begin
    m_seg[0] = 7'h3F; m_seg[1] = 7'h06; m_seg[2] = 7'h4F; m_seg[3] = 7'h66;
    m_dmask  = 4'hF;
    m_dot    = 4'h0;
    Enable   = 1'b1;
    Reset    = 1'b1;
    drive_inputs();

    // Reset state
    #2;
    check_dark("reset");
    chk("reset_z_anode", 32'(AnodeOutZ), 32'h0000_000F);

    // Release reset; first scan plus 64-cycle free run
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    k = 0;
    check_model(1'b0);
    repeat (64) begin
      step();
      check_model(1'b0);
    end
    chk("ft_count", 32'(ftc), 32'd2);

    // Seg1 changes mid-SHOW of slot 1; shown pattern must hold
    while (k < 76) begin
      step();
      check_model(1'b0);
    end
    Seg1 = 7'h5B;
    repeat (3) begin
      step();
      chk("seg_hold", 32'(SegOut), 32'h79);
      chk("anode_hold", 32'(AnodeOut), 32'hD);
    end
    step();
    check_model(1'b0);
    m_seg[1] = 7'h5B;
    while (k < 112) begin
      step();
      check_model(1'b0);
    end

    // Digit 2 masked, decimal point on digit 0 only
    m_dmask = 4'b1011;
    m_dot   = 4'b0001;
    drive_inputs();
    while (k < 152) begin
      step();
      check_model(1'b0);
    end
    m_dmask = 4'hF;
    m_dot   = 4'h0;
    drive_inputs();
    while (k < 181) begin
      step();
      check_model(1'b0);
    end

    // Asynchronous reset at cnt=5 of slot 2, between clock edges
    #2;
    Reset = 1'b1;
    #1;
    check_dark("async_reset");
    step();
    check_dark("reset_held");
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    k = 0;
    check_model(1'b0);
    while (k < 30) begin
      step();
      check_model(1'b0);
    end

    // Enable dropped for 3 cycles across the frame boundary
    Enable = 1'b0;
    repeat (3) begin
      step();
      check_dark("disabled");
    end
    Enable = 1'b1;
    k = 0;
    check_model(1'b1);
    repeat (40) begin
      step();
      check_model(1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
